// File: rtl/ycbcr422_to_rgb.sv
// YCbCr 4:2:2 to RGB888 converter.
// Beats arrive as {chroma, Y}. Two beats form a pixel pair that shares one
// Cb/Cr sample. Each complete pair is issued as two pixels on consecutive
// cycles into a 4-stage full-range BT.601 matrix (coefficients x256) with
// clamping. Handshake: there is no backpressure. src_valid qualifies a beat
// in the cycle it is high. dst_valid qualifies dst_data in the cycle it is
// high. dst_data holds its last value while dst_valid is low.
module ycbcr422_to_rgb #(
    parameter bit CB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        src_valid,
    input  logic        src_sol,
    input  logic [15:0] src_data,
    output logic        dst_valid,
    output logic [23:0] dst_data
);

    // Pair tracker and chroma reassembly
    logic       ph;        // 0: next beat is beat0, 1: next beat is beat1
    logic       pend;      // second pixel of an issued pair still to issue
    logic [7:0] y0;
    logic [7:0] c0;
    logic [7:0] yh;
    logic [7:0] cb_h;
    logic [7:0] cr_h;

    logic       is_beat0;
    logic       is_beat1;
    logic [7:0] cb_now;
    logic [7:0] cr_now;

    // S0 issue register
    logic       s0_valid;
    logic [7:0] s0_y;
    logic [7:0] s0_cb;
    logic [7:0] s0_cr;

    // S1 products
    logic               s1_valid;
    logic signed [17:0] s1_base;
    logic signed [17:0] s1_pr;    // 359*dcr
    logic signed [17:0] s1_pgb;   // 88*dcb
    logic signed [17:0] s1_pgr;   // 183*dcr
    logic signed [17:0] s1_pb;    // 454*dcb

    // S2 sums
    logic               s2_valid;
    logic signed [19:0] s2_r;
    logic signed [19:0] s2_g;
    logic signed [19:0] s2_b;

    // S1 combinational terms
    logic signed [8:0]  dcb_c;
    logic signed [8:0]  dcr_c;
    logic signed [17:0] base_c;

    // Shift right by 8 (arithmetic) and saturate to the 0..255 range.
    function automatic logic [7:0] clamp8(input logic signed [19:0] v);
        logic signed [19:0] s;
        s = v >>> 8;
        if (s < 20'sd0) begin
            return 8'd0;
        end else if (s > 20'sd255) begin
            return 8'd255;
        end else begin
            return s[7:0];
        end
    endfunction

    // Beat classification: src_sol forces a beat0 and drops any orphan beat0.
    always_comb begin
        is_beat0 = src_valid && (src_sol || !ph);
        is_beat1 = src_valid && ph && !src_sol;
        cb_now   = CB_FIRST ? c0 : src_data[15:8];
        cr_now   = CB_FIRST ? src_data[15:8] : c0;
    end

    // Front end: latch beat0, issue pixel0 on beat1, issue pixel1 the cycle after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph       <= 1'b0;
            pend     <= 1'b0;
            y0       <= 8'd0;
            c0       <= 8'd0;
            yh       <= 8'd0;
            cb_h     <= 8'd0;
            cr_h     <= 8'd0;
            s0_valid <= 1'b0;
            s0_y     <= 8'd0;
            s0_cb    <= 8'd0;
            s0_cr    <= 8'd0;
        end else begin
            if (is_beat0) begin
                y0 <= src_data[7:0];
                c0 <= src_data[15:8];
                ph <= 1'b1;
            end
            // A beat1 cannot coincide with pend: pend always follows a beat1,
            // which returns ph to 0.
            if (is_beat1) begin
                ph       <= 1'b0;
                yh       <= src_data[7:0];
                cb_h     <= cb_now;
                cr_h     <= cr_now;
                pend     <= 1'b1;
                s0_valid <= 1'b1;
                s0_y     <= y0;
                s0_cb    <= cb_now;
                s0_cr    <= cr_now;
            end else if (pend) begin
                pend     <= 1'b0;
                s0_valid <= 1'b1;
                s0_y     <= yh;
                s0_cb    <= cb_h;
                s0_cr    <= cr_h;
            end else begin
                s0_valid <= 1'b0;
            end
        end
    end

    // Chroma offsets and luma base for the S1 multipliers.
    always_comb begin
        dcb_c  = $signed({1'b0, s0_cb}) - 9'sd128;
        dcr_c  = $signed({1'b0, s0_cr}) - 9'sd128;
        base_c = $signed({2'b00, s0_y, 8'h80});  // 256*Y + 128
    end

    // S1: coefficient products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_base  <= 18'sd0;
            s1_pr    <= 18'sd0;
            s1_pgb   <= 18'sd0;
            s1_pgr   <= 18'sd0;
            s1_pb    <= 18'sd0;
        end else begin
            s1_valid <= s0_valid;
            s1_base  <= base_c;
            s1_pr    <= 18'sd359 * 18'(dcr_c);
            s1_pgb   <= 18'sd88  * 18'(dcb_c);
            s1_pgr   <= 18'sd183 * 18'(dcr_c);
            s1_pb    <= 18'sd454 * 18'(dcb_c);
        end
    end

    // S2: per-channel sums, wide enough that no combination can overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_r     <= 20'sd0;
            s2_g     <= 20'sd0;
            s2_b     <= 20'sd0;
        end else begin
            s2_valid <= s1_valid;
            s2_r     <= 20'(s1_base) + 20'(s1_pr);
            s2_g     <= 20'(s1_base) - 20'(s1_pgb) - 20'(s1_pgr);
            s2_b     <= 20'(s1_base) + 20'(s1_pb);
        end
    end

    // S3: shift, clamp and register the output; data holds between valid pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_valid <= 1'b0;
            dst_data  <= 24'd0;
        end else begin
            dst_valid <= s2_valid;
            if (s2_valid) begin
                dst_data <= {clamp8(s2_r), clamp8(s2_g), clamp8(s2_b)};
            end
        end
    end

endmodule
